// File: rtl/lcd_hd44780_writer.sv
// HD44780 4-bit bus write engine: turns a one-cycle write strobe into the full E/RS/DB[7:4] sequence plus execution wait.
// Optional macro LCD_LONG_EXEC_EN: clear/home commands wait T_CLR cycles instead of T_EXEC.
module lcd_hd44780_writer #(
  parameter int T_AS   = 2,
  parameter int T_EPW  = 12,
  parameter int T_H    = 2,
  parameter int T_EXEC = 1100,
  parameter int T_CLR  = 44000,
  parameter int CNT_W  = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic       wr_nib,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  typedef enum logic [2:0] {
    IDLE, SETUP_HI, PULSE_HI, HOLD_HI, SETUP_LO, PULSE_LO, HOLD_LO, EXEC
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   exec_load;
  logic               nib_q;
  logic [7:0]         data_q;
  logic               accept;
  logic               e_nxt, rs_nxt;
  logic [3:0]         db_nxt;

  assign accept = wr_valid && wr_ready;
  assign lcd_rw = 1'b0;

`ifdef LCD_LONG_EXEC_EN
  logic long_cmd;
  // lcd_rs still carries the latched register select throughout the transfer
  assign long_cmd  = !lcd_rs && !nib_q &&
                     ((data_q == 8'h01) || (data_q[7:1] == 7'b0000001));
  assign exec_load = long_cmd ? CNT_W'(T_CLR) : CNT_W'(T_EXEC);
`else
  logic unused_t_clr;
  assign unused_t_clr = ^CNT_W'(T_CLR);
  assign exec_load    = CNT_W'(T_EXEC);
`endif

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q - CNT_W'(1);
    rs_nxt    = lcd_rs;
    db_nxt    = lcd_db;
    case (state_q)
      IDLE: begin
        cnt_nxt = cnt_q;
        if (accept) begin
          state_nxt = SETUP_HI;
          cnt_nxt   = CNT_W'(T_AS);
          rs_nxt    = wr_rs;
          db_nxt    = wr_data[7:4];
        end
      end
      default: begin
        if (cnt_q == CNT_W'(1)) begin
          case (state_q)
            SETUP_HI: begin state_nxt = PULSE_HI; cnt_nxt = CNT_W'(T_EPW); end
            PULSE_HI: begin state_nxt = HOLD_HI;  cnt_nxt = CNT_W'(T_H);   end
            HOLD_HI: begin
              if (nib_q) begin
                state_nxt = EXEC;
                cnt_nxt   = exec_load;
              end else begin
                state_nxt = SETUP_LO;
                cnt_nxt   = CNT_W'(T_AS);
                db_nxt    = data_q[3:0];
              end
            end
            SETUP_LO: begin state_nxt = PULSE_LO; cnt_nxt = CNT_W'(T_EPW); end
            PULSE_LO: begin state_nxt = HOLD_LO;  cnt_nxt = CNT_W'(T_H);   end
            HOLD_LO:  begin state_nxt = EXEC;     cnt_nxt = exec_load;     end
            default:  begin state_nxt = IDLE;     cnt_nxt = '0;            end
          endcase
        end
      end
    endcase
    e_nxt = (state_nxt == PULSE_HI) || (state_nxt == PULSE_LO);
  end

  // Control and pin registers: every output comes straight from a flop
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_db   <= 4'h0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      wr_ready <= (state_nxt == IDLE);
      busy     <= (state_nxt != IDLE);
      lcd_e    <= e_nxt;
      lcd_rs   <= rs_nxt;
      lcd_db   <= db_nxt;
    end
  end

  // Request payload, captured on the accepting edge
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      nib_q  <= wr_nib;
      data_q <= wr_data;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Bench for lcd_hd44780_writer: directed and random transfers checked against a pulse-level model of the LCD bus.
module tb_lcd_hd44780_writer;
  localparam int T_AS = 1, T_EPW = 3, T_H = 1, T_EXEC = 5, T_CLR = 20;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic       wr_nib = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, busy, lcd_e, lcd_rw, lcd_rs;
  logic [3:0] lcd_db;

  int asserts = 0;
  int fails = 0;
  int glitch = 0;
  int rw_bad = 0;

  bit         p_rs[$];
  logic [3:0] p_db[$];
  int         p_w[$];
  bit         e_prev = 1'b0;
  bit         cur_rs;
  logic [3:0] cur_db;
  int         wid;

  lcd_hd44780_writer #(
    .T_AS(T_AS), .T_EPW(T_EPW), .T_H(T_H), .T_EXEC(T_EXEC), .T_CLR(T_CLR), .CNT_W(16)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rs(wr_rs), .wr_nib(wr_nib), .wr_data(wr_data), .busy(busy),
    .lcd_e(lcd_e), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_db(lcd_db)
  );

  always #5 sys_clk = ~sys_clk;

  // Bus observer: records each completed E pulse as (rs, db, width)
  always @(posedge sys_clk) begin
    #1;
    if (lcd_rw !== 1'b0) rw_bad++;
    if (!rst_n) begin
      e_prev = 1'b0;
    end else begin
      if (lcd_e === 1'b1) begin
        if (!e_prev) begin
          cur_rs = lcd_rs;
          cur_db = lcd_db;
          wid    = 1;
        end else begin
          wid++;
          if (lcd_rs !== cur_rs || lcd_db !== cur_db) glitch++;
        end
      end else if (e_prev) begin
        p_rs.push_back(cur_rs);
        p_db.push_back(cur_db);
        p_w.push_back(wid);
      end
      e_prev = (lcd_e === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: cycles from accepting edge until the engine is ready again
  function automatic int exp_lat(input bit rs, input bit nib, input logic [7:0] d);
    int phase = T_AS + T_EPW + T_H;
    int ex = T_EXEC;
`ifdef LCD_LONG_EXEC_EN
    if (!rs && !nib && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ex = T_CLR;
`endif
    return (nib ? 1 : 2) * phase + ex;
  endfunction

  task automatic clear_log();
    p_rs.delete();
    p_db.delete();
    p_w.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (wr_ready !== 1'b1 && n < 100) begin
      @(posedge sys_clk); #1; n++;
    end
    chk("ready_before_req", wr_ready, 1'b1);
  endtask

  task automatic send(input bit rs, input bit nib, input logic [7:0] d, input bit spam);
    int lat = 0;
    int nexp = nib ? 1 : 2;
    logic [3:0] exp_db;
    wait_ready();
    clear_log();
    @(negedge sys_clk);
    wr_valid = 1'b1; wr_rs = rs; wr_nib = nib; wr_data = d;
    @(posedge sys_clk); #1;
    wr_valid = 1'b0;
    wr_rs = 1'($urandom); wr_nib = 1'($urandom); wr_data = 8'($urandom);
    chk("accept_ready_low", wr_ready, 1'b0);
    chk("accept_busy_high", busy, 1'b1);
    if (spam) begin
      wr_valid = 1'b1; wr_data = 8'h55; wr_rs = ~rs; wr_nib = 1'b0;
    end
    do begin
      @(posedge sys_clk); #1; lat++;
      if (lat == 3) wr_valid = 1'b0;
    end while (wr_ready !== 1'b1 && lat < 200);
    wr_valid = 1'b0;
    chk("latency", lat, exp_lat(rs, nib, d));
    chk("busy_after", busy, 1'b0);
    chk("pulse_count", p_w.size(), nexp);
    for (int i = 0; i < nexp && i < p_w.size(); i++) begin
      exp_db = (i == 0) ? d[7:4] : d[3:0];
      chk("pulse_rs", p_rs[i], rs);
      chk("pulse_db", p_db[i], exp_db);
      chk("pulse_width", p_w[i], T_EPW);
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs_async", {wr_ready, busy, lcd_e, lcd_rw, lcd_rs, lcd_db}, 0);
    repeat (3) @(posedge sys_clk);
    #1 chk("reset_outputs_clocked", {wr_ready, busy, lcd_e, lcd_rw, lcd_rs, lcd_db}, 0);
    @(negedge sys_clk) rst_n = 1'b1;
    #1 chk("ready_before_first_edge", wr_ready, 1'b0);
    @(posedge sys_clk); #1;
    chk("ready_after_release", wr_ready, 1'b1);
    chk("busy_after_release", busy, 1'b0);

    send(1'b1, 1'b0, 8'h41, 1'b0);
    send(1'b0, 1'b1, 8'h30, 1'b0);
    send(1'b1, 1'b0, 8'hA7, 1'b1);
    send(1'b0, 1'b0, 8'h01, 1'b0);
    send(1'b0, 1'b0, 8'h02, 1'b0);
    send(1'b0, 1'b0, 8'h03, 1'b0);
    send(1'b0, 1'b0, 8'h04, 1'b0);
    send(1'b1, 1'b0, 8'h01, 1'b0);

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      send(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    // Abort while E is high in the low-nibble pulse
    wait_ready();
    clear_log();
    @(negedge sys_clk);
    wr_valid = 1'b1; wr_rs = 1'b1; wr_nib = 1'b0; wr_data = 8'h5A;
    @(posedge sys_clk); #1;
    wr_valid = 1'b0;
    n = 0;
    while (!(lcd_e === 1'b1 && p_w.size() == 1) && n < 100) begin
      @(posedge sys_clk); #1; n++;
    end
    chk("reached_pulse_lo", {lcd_e, lcd_db}, {1'b1, 4'hA});
    #2 rst_n = 1'b0;
    #1;
    chk("abort_lcd_e", lcd_e, 1'b0);
    chk("abort_outputs", {wr_ready, busy, lcd_rs, lcd_db}, 0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("ready_after_abort", wr_ready, 1'b1);
    send(1'b1, 1'b0, 8'hC3, 1'b0);

    chk("no_change_while_e_high", glitch, 0);
    chk("lcd_rw_always_low", rw_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
